// File: rtl/muldiv_cu.sv
// Iterative LA32R M-class unit: shift-add multiply and restoring divide,
// retiring UNROLL bits per cycle, with pipeline stall and one-cycle done strobe.
module muldiv_cu #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic [16:0]      op17,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             is_md,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_t;

  state_t state, state_nxt;

  sel_t             dec_sel;
  logic             dec_signed;
  logic             dec_div;
  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero_in;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   dividend_q;
  sel_t               sel_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;

  logic [2*WIDTH-1:0] step;
  logic [WIDTH:0]     r2, diff, sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    is_md      = 1'b1;
    dec_sel    = SEL_LO;
    dec_signed = 1'b0;
    dec_div    = 1'b0;
    case (op17)
      17'h00038: dec_sel = SEL_LO;
      17'h00039: begin dec_sel = SEL_HI;  dec_signed = 1'b1; end
      17'h0003A: dec_sel = SEL_HI;
      17'h00040: begin dec_sel = SEL_QUO; dec_signed = 1'b1; dec_div = 1'b1; end
      17'h00041: begin dec_sel = SEL_REM; dec_signed = 1'b1; dec_div = 1'b1; end
      17'h00042: begin dec_sel = SEL_QUO; dec_div = 1'b1; end
      17'h00043: begin dec_sel = SEL_REM; dec_div = 1'b1; end
      default:   is_md = 1'b0;
    endcase
  end

  // Operand magnitudes; mul.w low half is sign-agnostic so it runs unsigned.
  always_comb begin
    accept      = (state == IDLE) && start && is_md && !flush;
    a_neg       = dec_signed && src_a[WIDTH-1];
    b_neg       = dec_signed && src_b[WIDTH-1];
    abs_a       = a_neg ? (~src_a + ONE_W) : src_a;
    abs_b       = b_neg ? (~src_b + ONE_W) : src_b;
    div_zero_in = dec_div && (src_b == '0);
  end

  // Multiply and divide share one accumulator: {high/remainder, low/quotient}.
  always_comb begin
    step = acc;
    r2   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_q) begin
        r2   = step[2*WIDTH-1:WIDTH-1];
        diff = r2 - {1'b0, mag_b};
        if (!diff[WIDTH])
          step = {diff[WIDTH-1:0], step[WIDTH-2:0], 1'b1};
        else
          step = {step[2*WIDTH-2:0], 1'b0};
      end else begin
        sum  = {1'b0, step[2*WIDTH-1:WIDTH]} + (step[0] ? {1'b0, mag_b} : '0);
        step = {sum, step[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod    = neg_res_q ? (~acc + ONE_2W) : acc;
    quo     = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    fix_val = '0;
    case (sel_q)
      SEL_LO:  fix_val = prod[WIDTH-1:0];
      SEL_HI:  fix_val = prod[2*WIDTH-1:WIDTH];
      SEL_QUO: fix_val = dz_q ? '1 : (neg_res_q ? (~quo + ONE_W) : quo);
      SEL_REM: fix_val = dz_q ? dividend_q : (neg_rem_q ? (~rem + ONE_W) : rem);
      default: fix_val = '0;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero_in ? FIX : CALC;
      CALC: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == CW'(1))
          state_nxt = FIX;
      end
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush drops stall in its own cycle so the flushed slot never waits on us.
  always_comb begin
    busy  = (state == CALC) || (state == FIX);
    stall = !flush && (((state == IDLE) && start && is_md) || busy);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt        <= '0;
      acc        <= '0;
      mag_b      <= '0;
      dividend_q <= '0;
      sel_q      <= SEL_LO;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= (state == FIX) && !flush;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= CW'(STEPS);
            acc        <= {{WIDTH{1'b0}}, abs_a};
            mag_b      <= abs_b;
            dividend_q <= src_a;
            sel_q      <= dec_sel;
            is_div_q   <= dec_div;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dz_q       <= div_zero_in;
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= step;
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!flush)
            result <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_cu.sv
// Directed bench for muldiv_cu: a default-width instance and an UNROLL=4
// instance, expected results queued at issue and popped at the done strobe.
module tb_muldiv_cu;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic [16:0] op17;
  logic        start1, start4, flush;
  logic [31:0] src_a, src_b;

  logic        is_md1, stall1, busy1, done1;
  logic [31:0] result1;
  logic        is_md4, stall4, busy4, done4;
  logic [31:0] result4;

  logic        use4;
  logic        cur_done, cur_stall;
  logic [31:0] cur_result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  muldiv_cu dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op17(op17), .start(start1),
    .flush(flush), .src_a(src_a), .src_b(src_b), .is_md(is_md1),
    .stall(stall1), .busy(busy1), .done(done1), .result(result1)
  );

  muldiv_cu #(.WIDTH(32), .UNROLL(4)) dut4 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op17(op17), .start(start4),
    .flush(flush), .src_a(src_a), .src_b(src_b), .is_md(is_md4),
    .stall(stall4), .busy(busy4), .done(done4), .result(result4)
  );

  assign cur_done   = use4 ? done4   : done1;
  assign cur_stall  = use4 ? stall4  : stall1;
  assign cur_result = use4 ? result4 : result1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then follow it to its done strobe within a bounded wait.
  task automatic applyStimulus(input logic [16:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp,
                               input int lat, input string tag);
    int          cyc;
    int          stalls;
    logic [31:0] e;
    @(negedge cpu_clk);
    op17  = op;
    src_a = a;
    src_b = b;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    exp_q.push_back(exp);
    #1;
    stalls = cur_stall ? 1 : 0;
    @(negedge cpu_clk);
    start1 = 1'b0;
    start4 = 1'b0;
    #1;
    cyc = 1;
    while (cur_done !== 1'b1 && cyc < 200) begin
      stalls += cur_stall ? 1 : 0;
      @(negedge cpu_clk);
      #1;
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, lat);
    checkOutput({tag, " stall cycles"}, stalls, lat);
    checkOutput({tag, " stall in DONE"}, {31'b0, cur_stall}, 32'd0);
    e = exp_q.pop_front();
    checkOutput({tag, " result"}, cur_result, e);
  endtask

  initial begin
    int          done_cnt;
    logic [31:0] prev;
    cpu_rstn = 1'b0;
    start1   = 1'b0;
    start4   = 1'b0;
    flush    = 1'b0;
    op17     = '0;
    src_a    = '0;
    src_b    = '0;
    use4     = 1'b0;

    repeat (2) @(negedge cpu_clk);
    checkOutput("reset busy",   {31'b0, busy1}, 32'd0);
    checkOutput("reset done",   {31'b0, done1}, 32'd0);
    checkOutput("reset result", result1, 32'd0);
    cpu_rstn = 1'b1;

    applyStimulus(17'h00039, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 34, "mulh.w");
    applyStimulus(17'h00038, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 34, "mul.w");
    applyStimulus(17'h0003A, 32'hFFFFFFFE, 32'h3, 32'h00000002, 34, "mulh.wu");
    applyStimulus(17'h00040, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 34, "div.w");
    applyStimulus(17'h00041, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 34, "mod.w");
    applyStimulus(17'h00042, 32'h7, 32'h2, 32'h3, 34, "div.wu");
    applyStimulus(17'h00043, 32'h7, 32'h2, 32'h1, 34, "mod.wu");
    applyStimulus(17'h00042, 32'h5, 32'h0, 32'hFFFFFFFF, 2, "div.wu by zero");
    applyStimulus(17'h00041, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 2, "mod.w by zero");
    applyStimulus(17'h00040, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "div.w overflow");

    // Non-M opcode with start must not stall or produce a result.
    @(negedge cpu_clk);
    op17   = 17'h00020;
    start1 = 1'b1;
    #1;
    checkOutput("non-M is_md", {31'b0, is_md1}, 32'd0);
    checkOutput("non-M stall", {31'b0, stall1}, 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge cpu_clk);
      #1;
      done_cnt += (done1 || busy1) ? 1 : 0;
    end
    start1 = 1'b0;
    checkOutput("non-M activity", done_cnt, 32'd0);

    // Flush a divide mid-CALC.
    prev = result1;
    @(negedge cpu_clk);
    op17   = 17'h00040;
    src_a  = 32'd100;
    src_b  = 32'd3;
    start1 = 1'b1;
    @(negedge cpu_clk);
    start1 = 1'b0;
    repeat (9) @(negedge cpu_clk);
    flush = 1'b1;
    #1;
    checkOutput("flush stall", {31'b0, stall1}, 32'd0);
    @(negedge cpu_clk);
    flush = 1'b0;
    #1;
    checkOutput("flush busy", {31'b0, busy1}, 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge cpu_clk);
      done_cnt += done1 ? 1 : 0;
    end
    checkOutput("flush no done", done_cnt, 32'd0);
    checkOutput("flush result held", result1, prev);

    applyStimulus(17'h00038, 32'd3, 32'd5, 32'd15, 34, "mul.w after flush");

    // Asynchronous reset in the middle of a multiply.
    @(negedge cpu_clk);
    op17   = 17'h00038;
    src_a  = 32'd9;
    src_b  = 32'd9;
    start1 = 1'b1;
    @(negedge cpu_clk);
    start1 = 1'b0;
    repeat (5) @(negedge cpu_clk);
    #2;
    cpu_rstn = 1'b0;
    #1;
    checkOutput("async reset busy",   {31'b0, busy1},  32'd0);
    checkOutput("async reset done",   {31'b0, done1},  32'd0);
    checkOutput("async reset result", result1,         32'd0);
    checkOutput("async reset stall",  {31'b0, stall1}, 32'd0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    applyStimulus(17'h00038, 32'd7, 32'd6, 32'd42, 34, "mul.w after reset");
    applyStimulus(17'h00041, 32'h80000000, 32'hFFFFFFFF, 32'h0, 34, "mod.w overflow");

    use4 = 1'b1;
    applyStimulus(17'h00038, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 10, "x4 mul.w");
    applyStimulus(17'h00042, 32'd100, 32'd7, 32'd14, 10, "x4 div.wu back-to-back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_cu.md
Name: muldiv_cu

Overview:
Iterative multiply/divide control-and-datapath unit for the LA32R EX stage. It decodes the M-class opcodes (mul.w, mulh.w, mulh.wu, div.w, mod.w, div.wu, mod.wu) from the upper 17 instruction bits; the single-cycle control unit maps these to ALU_ADD by default. It runs a multi-cycle shift-add / restoring-divide FSM, generalised by operand width and bits retired per cycle. It stalls the pipeline while busy and presents the result on a one-cycle done strobe.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and at least 4.
UNROLL, 1, bits retired per CALC cycle; legal values are 1, 2 and 4; must divide WIDTH.

Ports:
cpu_clk  in  1  clock, rising edge.
cpu_rstn  in  1  asynchronous active-low reset.
op17  in  17  instruction bits [31:15].
start  in  1  EX-stage instruction valid.
flush  in  1  pipeline flush; cancels any operation in progress.
src_a  in  WIDTH  rj operand.
src_b  in  WIDTH  rk operand.
is_md  out  1  combinational; op17 is one of the seven M-class opcodes.
stall  out  1  combinational pipeline stall request.
busy  out  1  registered; FSM is in CALC or FIX.
done  out  1  registered; result valid, one-cycle pulse.
result  out  WIDTH  registered; final value, held until the next done.

Behaviour:
- Opcode decode (op17 hex):
  - 00038 mul.w: low product half.
  - 00039 mulh.w: signed high half.
  - 0003A mulh.wu: unsigned high half.
  - 00040 div.w: signed quotient.
  - 00041 mod.w: signed remainder.
  - 00042 div.wu: unsigned quotient.
  - 00043 mod.wu: unsigned remainder.
  - Any other value: is_md=0.
- Reset (async, cpu_rstn=0): state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- States:
  - IDLE: if start & is_md & !flush, latch the op and operand magnitudes (signed ops use two's-complement absolute values), latch the result signs, load iteration counter = WIDTH/UNROLL, go to CALC. Exception: divide ops with src_b==0 go straight to FIX.
  - CALC: retire UNROLL bits per cycle and decrement the counter. At counter==1, go to FIX.
    - Multiply: shift-add into a 2*WIDTH-bit accumulator.
    - Divide: restoring divide (shift remainder, trial subtract, set quotient bit).
  - FIX: apply sign correction and select the output.
    - Product is negated if the signs of a and b differ (signed ops only).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
    - Write result, go to DONE.
  - DONE: done=1 for exactly this cycle; start is ignored; go to IDLE.
- Latency: start is sampled at edge 0, done is high in cycle WIDTH/UNROLL+2. With defaults this is 34 cycles. The divide-by-zero path takes 2 cycles.
- stall = (IDLE & start & is_md & !flush) | CALC | FIX. stall is 0 in DONE, so the EX instruction advances with result in that cycle.
- busy = CALC | FIX (registered state decode).
- Divide by zero:
  - Quotient = all ones.
  - Remainder = the dividend unchanged (original signed value, not the magnitude).
- Signed overflow (div.w of -2^(WIDTH-1) by -1): quotient = -2^(WIDTH-1), remainder = 0. The normal path yields this; no special case is needed.
- mul.w low half is identical for signed and unsigned operands.
- flush in any state: go to IDLE at the next edge with no done pulse. result holds its old value; stall=0 in the flush cycle.
- Back-to-back operations: a new start is accepted in the IDLE cycle immediately following DONE.
- Non-M ops with start=1: no effect; stall=0.

Test Plan:
- Reset: hold cpu_rstn=0 mid-CALC of an active mul.w -> busy=0, done=0, result=0, stall=0 asynchronously. After release, IDLE; a new op completes normally.
- mulh.w a=0xFFFFFFFE (-2), b=0x00000003 -> stall high for 34 cycles; done in cycle 34 with result=0xFFFFFFFF. Repeat with mul.w -> 0xFFFFFFFA. Repeat with mulh.wu -> 0x00000002.
- div.w a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. mod.w, same operands -> 0xFFFFFFFF. div.wu a=7, b=2 -> 3. mod.wu -> 1.
- Boundary cases:
  - div.wu 5/0 -> 0xFFFFFFFF with done 2 cycles after start.
  - mod.w a=0xFFFFFFF9, b=0 -> 0xFFFFFFF9.
  - div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - mod.w, same operands -> 0.
- Assert flush at cycle 10 of a div.w -> no done pulse; stall low; result unchanged. A following mul.w 3*5 -> 15.
- UNROLL=4: mul.w 0x12345678 * 0x9ABCDEF0 -> low half 0x242D2080; latency 10 cycles. Back-to-back div.wu 100/7 -> 14 accepted the cycle after DONE.
